alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU. Same 4-bit opcode map.
- Adds WIDTH generalisation, valid/ready handshakes on both sides, and registered, correctly defined C/N/V/Z flags.
- Multiply is an iterative shift-add unit.
- Sits between the register-file read stage and the writeback/flags stage of the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 4.
- CNTW, $clog2(WIDTH)+1, iteration counter width. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  opcode, sampled at accept
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- carry_in  in  1  carry/borrow in for ADC/SBC, sampled at accept
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- carry_out  out  1  C flag
- sign_out  out  1  N flag
- overflow_out  out  1  V flag
- zero_out  out  1  Z flag
- busy  out  1  high in BUSY state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; result=0; all flags 0; out_valid=0; counter=0.
  - in_ready=1 once reset releases.
  - Reset mid-multiply abandons the operation; no output is produced.
- Accept: rising edge with in_valid&&in_ready. a, b, op and carry_in are latched.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops.
- FSM transitions:
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of MUL (0100/0101).
  - BUSY -> DONE after WIDTH iterations.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE/BUSY on out_ready with a simultaneous accept.
- out_valid is high exactly in DONE.
- result and flags are held stable while out_valid && !out_ready.
- Latency from accept edge to out_valid:
  - single-cycle ops: 1 cycle
  - MUL: WIDTH+1 cycles
- Opcodes:
  - 0000 ADD
  - 0001 ADC (a+b+cin)
  - 0010 SUB
  - 0011 SBC (a-b-cin)
  - 0100 MUL, low WIDTH bits
  - 0101 MULH, high WIDTH bits of the unsigned product
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - 1001 SHL
  - 1010 SHR (logical)
  - 1011 NOT a
  - 1100 CMP (a-b)
  - 1101 INC a
  - 1110 DEC a
  - 1111 PASS a
- All arithmetic is computed at WIDTH+1 bits.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0). Both apply to every op.
  - ADD/ADC/INC: C = carry out of bit WIDTH-1; V = signed overflow (operands same sign, result different sign).
  - SUB/SBC/CMP/DEC: C = borrow (1 when unsigned a < b+cin); V = signed overflow (operands differ in sign, result sign != a sign).
  - MUL/MULH: C = V = (high half of product != 0).
  - SHL/SHR, b < WIDTH: C = last bit shifted out; b==0 gives C=0. V=0.
  - SHL/SHR, b >= WIDTH: result=0, C=0, V=0.
  - Logical, NOT, PASS: C=V=0.
- Multiplier: a radix-2 shift-add unit, one bit of b per cycle, with a 2*WIDTH accumulator. Operands are latched, so input changes during BUSY have no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined:
  - Opcode 1111 = DIVU: unsigned restoring division, WIDTH iterations in BUSY, latency WIDTH+1.
  - result = quotient; C = (remainder != 0); V = 0.
  - Divide by zero: result = all ones, C=1, V=1, same latency.
- Undefined: 1111 = PASS a, 1-cycle latency, and no divider logic is synthesised.

Test Plan:
- Reset check: assert rst_n=0 mid-MUL, then release -> out_valid=0, result=0, flags 0, in_ready=1 on the next cycle.
- WIDTH=16, ADD a=16'h7FFF b=16'h0001 -> result=16'h8000, N=1, V=1, C=0, Z=0, out_valid 1 cycle after accept.
- SUB a=16'h0000 b=16'h0001 -> result=16'hFFFF, C=1, V=0, N=1. Then ADC a=16'hFFFF b=0 cin=1 -> result=0, Z=1, C=1.
- MUL a=16'h0100 b=16'h0100 -> result=0, C=V=1, out_valid 17 cycles after accept. MULH with the same operands -> 16'h0001.
- SHL a=16'h8001 b=1 -> result=16'h0002, C=1. SHR with b=16 -> result=0, C=0, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles on an AND result -> result stable and in_ready=0 throughout. Issue back-to-back ops with out_ready=1 -> one result per cycle.
- With ALU_SEQ_DIV_EN: DIVU 100/7 -> result 14, C=1. DIVU x/0 -> result 16'hFFFF, C=V=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and C/N/V/Z flags; MUL/MULH use an iterative shift-add unit.
// Optional ALU_SEQ_DIV_EN turns opcode 1111 into DIVU, a restoring divider; without it, 1111 is PASS a.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             sign_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             busy
);
    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam int M    = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_ADC = 4'b0001, OP_SUB = 4'b0010, OP_SBC = 4'b0011,
                           OP_MUL = 4'b0100, OP_MULH = 4'b0101, OP_AND = 4'b0110, OP_OR = 4'b0111,
                           OP_XOR = 4'b1000, OP_SHL = 4'b1001, OP_SHR = 4'b1010, OP_NOT = 4'b1011,
                           OP_CMP = 4'b1100, OP_INC = 4'b1101, OP_DEC = 4'b1110, OP_PASS_DIVU = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_c, r_v, r_n, r_z;

    logic               w_accept, w_multi, w_last;
    logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;
    logic [WIDTH-1:0]   w_addb, w_subb;
    logic               w_acin, w_scin, w_shbig;
    logic [CNTW-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_res, w_fin_res;
    logic               w_c, w_v, w_fin_c, w_fin_v;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_hi;

`ifdef ALU_SEQ_DIV_EN
    logic               w_div_op, w_qbit;
    logic [WIDTH:0]     w_rem_sh, w_div_dif;
    assign w_multi   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_PASS_DIVU);
    assign w_div_op  = (r_op == OP_PASS_DIVU);
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_dif = w_rem_sh - {1'b0, r_opnd};
    assign w_qbit    = !w_div_dif[WIDTH];
`else
    assign w_multi   = (op == OP_MUL) || (op == OP_MULH);
`endif

    // Operand B is replaced by 1 for INC/DEC so the shared adder/subtractor flags apply unchanged.
    always_comb begin
        w_addb = b;
        w_acin = 1'b0;
        w_subb = b;
        w_scin = 1'b0;
        if (op == OP_ADC) w_acin = carry_in;
        if (op == OP_SBC) w_scin = carry_in;
        if (op == OP_INC) w_addb = {{(WIDTH-1){1'b0}}, 1'b1};
        if (op == OP_DEC) w_subb = {{(WIDTH-1){1'b0}}, 1'b1};
    end

    assign w_sum   = {1'b0, a} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_acin};
    assign w_dif   = {1'b0, a} - {1'b0, w_subb} - {{WIDTH{1'b0}}, w_scin};
    assign w_shbig = ({1'b0, b} >= (WIDTH+1)'(WIDTH));
    assign w_shamt = b[CNTW-1:0];
    assign w_shl   = {1'b0, a} << w_shamt;
    assign w_shr   = {a, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[M] == w_addb[M]) && (w_sum[M] != a[M]);
            end
            OP_SUB, OP_SBC, OP_CMP, OP_DEC: begin
                w_res = w_dif[M:0];
                w_c   = w_dif[WIDTH];
                w_v   = (a[M] != w_subb[M]) && (w_dif[M] != a[M]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL: if (!w_shbig) begin
                w_res = w_shl[M:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: if (!w_shbig) begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
`ifndef ALU_SEQ_DIV_EN
            OP_PASS_DIVU: w_res = a;
`endif
            default: ;
        endcase
    end

    // Multiplier in r_acc low half shifts out LSB-first while partial sums enter from the top.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
`ifdef ALU_SEQ_DIV_EN
    assign w_acc_nxt = w_div_op
                     ? {(w_qbit ? w_div_dif[M:0] : w_rem_sh[M:0]), r_acc[WIDTH-2:0], w_qbit}
                     : {w_mul_sum, r_acc[WIDTH-1:1]};
`else
    assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif
    assign w_hi = w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fin_res = (r_op == OP_MULH) ? w_hi : w_acc_nxt[M:0];
        w_fin_c   = |w_hi;
        w_fin_v   = |w_hi;
`ifdef ALU_SEQ_DIV_EN
        if (w_div_op) begin
            w_fin_res = (r_opnd == '0) ? {WIDTH{1'b1}} : w_acc_nxt[M:0];
            w_fin_c   = (r_opnd == '0) || (|w_hi);
            w_fin_v   = (r_opnd == '0);
        end
`endif
    end

    assign w_last   = (r_state == S_BUSY) && (r_cnt == CNTW'(WIDTH-1));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_multi ? S_BUSY : S_DONE;
            S_BUSY: if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready && in_valid) w_state_nxt = w_multi ? S_BUSY : S_DONE;
                else if (out_ready)        w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_cnt <= '0;
            if (w_multi) begin
`ifdef ALU_SEQ_DIV_EN
                r_opnd <= (op == OP_PASS_DIVU) ? b : a;
                r_acc  <= {{WIDTH{1'b0}}, ((op == OP_PASS_DIVU) ? a : b)};
`else
                r_opnd <= a;
                r_acc  <= {{WIDTH{1'b0}}, b};
`endif
            end else begin
                r_result <= w_res;
                r_c      <= w_c;
                r_v      <= w_v;
                r_n      <= w_res[M];
                r_z      <= (w_res == '0);
            end
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_fin_res;
                r_c      <= w_fin_c;
                r_v      <= w_fin_v;
                r_n      <= w_fin_res[M];
                r_z      <= (w_fin_res == '0);
            end
        end
    end

    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state == S_BUSY);
    assign result       = r_result;
    assign carry_out    = r_c;
    assign sign_out     = r_n;
    assign overflow_out = r_v;
    assign zero_out     = r_z;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16 (DIVU steps only when ALU_SEQ_DIV_EN is defined).
module tb_alu_seq;
    logic        clk, rst_n, in_valid, in_ready, carry_in, out_valid, out_ready;
    logic [3:0]  op;
    logic [15:0] a, b, result;
    logic        carry_out, sign_out, overflow_out, zero_out, busy;
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .sign_out(sign_out), .overflow_out(overflow_out),
        .zero_out(zero_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one op with out_ready low, then measure cycles until out_valid (accept cycle counts as 1).
    task automatic issue(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb, input logic ci);
        @(negedge clk);
        op = o; a = va; b = vb; carry_in = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; carry_in = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] r, input logic c, input logic n,
                              input logic v, input logic z, input int l);
        chk({tag, " latency"}, lat, l);
        chk({tag, " result"}, result, r);
        chk({tag, " C"}, carry_out, c);
        chk({tag, " N"}, sign_out, n);
        chk({tag, " V"}, overflow_out, v);
        chk({tag, " Z"}, zero_out, z);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'h0; a = '0; b = '0; carry_in = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset result", result, 16'h0000);
        chk("reset flags", {carry_out, sign_out, overflow_out, zero_out}, 4'b0000);
        chk("reset busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", in_ready, 1'b1);

        issue(4'b0000, 16'h7FFF, 16'h0001, 1'b0); expect_out("ADD ovf", 16'h8000, 0, 1, 1, 0, 1); release_out();
        issue(4'b0010, 16'h0000, 16'h0001, 1'b0); expect_out("SUB borrow", 16'hFFFF, 1, 1, 0, 0, 1); release_out();
        issue(4'b0001, 16'hFFFF, 16'h0000, 1'b1); expect_out("ADC wrap", 16'h0000, 1, 0, 0, 1, 1); release_out();
        issue(4'b0011, 16'h0005, 16'h0003, 1'b1); expect_out("SBC", 16'h0001, 0, 0, 0, 0, 1); release_out();
        issue(4'b1100, 16'h0003, 16'h0005, 1'b0); expect_out("CMP", 16'hFFFE, 1, 1, 0, 0, 1); release_out();
        issue(4'b1110, 16'h8000, 16'h1234, 1'b0); expect_out("DEC ovf", 16'h7FFF, 0, 0, 1, 0, 1); release_out();
        issue(4'b1101, 16'hFFFF, 16'h0000, 1'b0); expect_out("INC wrap", 16'h0000, 1, 0, 0, 1, 1); release_out();
        issue(4'b1101, 16'h7FFF, 16'h0000, 1'b0); expect_out("INC ovf", 16'h8000, 0, 1, 1, 0, 1); release_out();

        @(negedge clk);
        op = 4'b0100; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("MUL busy", busy, 1'b1);
        chk("MUL in_ready in BUSY", in_ready, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        expect_out("MUL", 16'h0000, 1, 0, 1, 1, 17); release_out();
        issue(4'b0101, 16'h0100, 16'h0100, 1'b0); expect_out("MULH", 16'h0001, 1, 0, 1, 0, 17); release_out();
        issue(4'b0100, 16'h0012, 16'h0034, 1'b0); expect_out("MUL small", 16'h03A8, 0, 0, 0, 0, 17); release_out();

        issue(4'b1001, 16'h8001, 16'h0001, 1'b0); expect_out("SHL 1", 16'h0002, 1, 0, 0, 0, 1); release_out();
        issue(4'b1010, 16'h8001, 16'h0010, 1'b0); expect_out("SHR 16", 16'h0000, 0, 0, 0, 1, 1); release_out();
        issue(4'b1010, 16'h0003, 16'h0001, 1'b0); expect_out("SHR 1", 16'h0001, 1, 0, 0, 0, 1); release_out();
        issue(4'b1001, 16'h8001, 16'h0000, 1'b0); expect_out("SHL 0", 16'h8001, 0, 1, 0, 0, 1); release_out();

`ifdef ALU_SEQ_DIV_EN
        issue(4'b1111, 16'd100, 16'd7, 1'b0); expect_out("DIVU 100/7", 16'd14, 1, 0, 0, 0, 17); release_out();
        issue(4'b1111, 16'h1234, 16'h0000, 1'b0); expect_out("DIVU by 0", 16'hFFFF, 1, 1, 1, 0, 17); release_out();
`else
        issue(4'b1111, 16'h1234, 16'h5678, 1'b0); expect_out("PASS", 16'h1234, 0, 0, 0, 0, 1); release_out();
`endif

        issue(4'b0110, 16'hF0F0, 16'hFF00, 1'b0); expect_out("AND", 16'hF000, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'(i); b = 16'h0000;
            chk("hold result", result, 16'hF000);
            chk("hold in_ready", in_ready, 1'b0);
            chk("hold out_valid", out_valid, 1'b1);
        end
        release_out();

        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        op = 4'b1000; a = 16'h00FF; b = 16'h0F0F;
        @(negedge clk);
        chk("b2b XOR valid", out_valid, 1'b1);
        chk("b2b XOR result", result, 16'h0FF0);
        chk("b2b in_ready", in_ready, 1'b1);
        op = 4'b0111; a = 16'h1200; b = 16'h0034;
        @(negedge clk);
        chk("b2b OR result", result, 16'h1234);
        op = 4'b1011; a = 16'h00FF;
        @(negedge clk);
        chk("b2b NOT result", result, 16'hFF00);
        op = 4'b0000; a = 16'h0001; b = 16'h0002;
        @(negedge clk);
        chk("b2b ADD valid", out_valid, 1'b1);
        chk("b2b ADD result", result, 16'h0003);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b drained", out_valid, 1'b0);
        out_ready = 1'b0;

        @(negedge clk);
        op = 4'b0100; a = 16'h00FF; b = 16'h00FF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-MUL busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid-MUL reset busy", busy, 1'b0);
        chk("mid-MUL reset result", result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset in_ready", in_ready, 1'b1);
        chk("after reset flags", {carry_out, sign_out, overflow_out, zero_out}, 4'b0000);
        repeat (20) @(negedge clk);
        chk("abandoned MUL no output", out_valid, 1'b0);
        chk("abandoned MUL result", result, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
